// File: rtl/axis_reg_fifo.sv
// AXI-Stream register FIFO with a registered head word, fill level, almost-full flag and flush.
// Both stream sides use a full valid&ready handshake; tready_o and tvalid_o are registered.
module axis_reg_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              flush_i,
  input  logic              tvalid_i,
  output logic              tready_o,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic              tlast_i,
  output logic              tvalid_o,
  input  logic              tready_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tlast_o,
  output logic [CNT_W-1:0]  level_o,
  output logic              almost_full_o,
  output logic [1:0]        state_o
);

  // Handshake: a word moves on a side only at a rising edge where valid and ready are both 1.
  // The producer holds tvalid_i/tdata_i/tlast_i until accepted; tready_o never depends on tready_i.

  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ACTIVE = 2'd1, ST_FULL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   level_d;
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W:0]    mem [DEPTH];
  logic [DATA_W:0]    head_d;
  logic               push, pop;

  assign push    = tvalid_i & tready_o;
  assign pop     = tvalid_o & tready_i;
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    level_d = level_o;
    wr_d    = wr_q;
    rd_d    = rd_q;
    head_d  = {tlast_o, tdata_o};
    if (flush_i) begin
      state_d = ST_EMPTY;
      level_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ACTIVE;
            level_d = CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (push && !pop) begin
            level_d = level_o + CNT_W'(1);
            if (level_d == CNT_W'(DEPTH)) state_d = ST_FULL;
          end else if (pop && !push) begin
            level_d = level_o - CNT_W'(1);
            if (level_d == '0) state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_ACTIVE;
            level_d = CNT_W'(DEPTH - 1);
          end
        end
        default: begin
          state_d = ST_EMPTY;
          level_d = '0;
        end
      endcase
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      // The new head is the incoming word when it lands exactly at the next read slot.
      if (push && (rd_d == wr_q)) head_d = {tlast_i, tdata_i};
      else if (pop)               head_d = mem[rd_d];
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= ST_EMPTY;
      level_o       <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      tdata_o       <= '0;
      tlast_o       <= 1'b0;
      tvalid_o      <= 1'b0;
      tready_o      <= 1'b1;
      almost_full_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_o       <= level_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      {tlast_o, tdata_o} <= head_d;
      tvalid_o      <= (level_d != '0);
      tready_o      <= (level_d < CNT_W'(DEPTH));
      almost_full_o <= (level_d >= CNT_W'(AF_THRESH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_q] <= {tlast_i, tdata_i};
  end

endmodule

// File: tb/tb_axis_reg_fifo.sv
// Directed bench for axis_reg_fifo: fill/drain, streaming, flush, async reset, plus a
// randomised-handshake scoreboard run on a 16-bit, 8-deep instance.
module tb_axis_reg_fifo;

  logic clk_i = 1'b0;
  logic arstn_i;
  always #5 clk_i = ~clk_i;

  // DEPTH=4, DATA_W=8 instance
  logic       flush_i, tvalid_i, tready_o, tlast_i, tvalid_o, tready_i, tlast_o, almost_full_o;
  logic [7:0] tdata_i, tdata_o;
  logic [2:0] level_o;
  logic [1:0] state_o;

  // DEPTH=8, DATA_W=16 instance
  logic        tvalid8_i, tready8_o, tlast8_i, tvalid8_o, tready8_i, tlast8_o, af8_o;
  logic [15:0] tdata8_i, tdata8_o;
  logic [3:0]  level8_o;
  logic [1:0]  state8_o;

  axis_reg_fifo #(.DATA_W(8), .DEPTH(4)) u_dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(flush_i),
    .tvalid_i(tvalid_i), .tready_o(tready_o), .tdata_i(tdata_i), .tlast_i(tlast_i),
    .tvalid_o(tvalid_o), .tready_i(tready_i), .tdata_o(tdata_o), .tlast_o(tlast_o),
    .level_o(level_o), .almost_full_o(almost_full_o), .state_o(state_o)
  );

  axis_reg_fifo #(.DATA_W(16), .DEPTH(8)) u_dut8 (
    .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(1'b0),
    .tvalid_i(tvalid8_i), .tready_o(tready8_o), .tdata_i(tdata8_i), .tlast_i(tlast8_i),
    .tvalid_o(tvalid8_o), .tready_i(tready8_i), .tdata_o(tdata8_o), .tlast_o(tlast8_o),
    .level_o(level8_o), .almost_full_o(af8_o), .state_o(state8_o)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_empty_outputs(input string tag);
    check({tag, ".tready"}, 32'(tready_o), 32'd1);
    check({tag, ".tvalid"}, 32'(tvalid_o), 32'd0);
    check({tag, ".level"},  32'(level_o),  32'd0);
    check({tag, ".af"},     32'(almost_full_o), 32'd0);
  endtask

  initial begin
    logic [7:0] t1_data [4];
    logic [2:0] t1_level [4];
    logic       t1_af [4];
    logic       t1_rdy [4];
    t1_data  = '{8'h11, 8'h22, 8'h33, 8'h44};
    t1_level = '{3'd1, 3'd2, 3'd3, 3'd4};
    t1_af    = '{1'b0, 1'b0, 1'b1, 1'b1};
    t1_rdy   = '{1'b1, 1'b1, 1'b1, 1'b0};

    arstn_i = 1'b0; flush_i = 1'b0; tvalid_i = 1'b0; tdata_i = '0; tlast_i = 1'b0; tready_i = 1'b0;
    tvalid8_i = 1'b0; tdata8_i = '0; tlast8_i = 1'b0; tready8_i = 1'b0;
    repeat (2) tick();
    check_empty_outputs("reset");
    check("reset.tdata", 32'(tdata_o), 32'h0);
    check("reset.tlast", 32'(tlast_o), 32'h0);
    check("reset.state", 32'(state_o), 32'd0);
    arstn_i = 1'b1;
    tick();

    // T1: fill with downstream stalled
    for (int i = 0; i < 4; i++) begin
      tvalid_i = 1'b1; tdata_i = t1_data[i]; tlast_i = 1'b0;
      tick();
      check("t1.level", 32'(level_o), 32'(t1_level[i]));
      check("t1.af",    32'(almost_full_o), 32'(t1_af[i]));
      check("t1.tready", 32'(tready_o), 32'(t1_rdy[i]));
      check("t1.tvalid", 32'(tvalid_o), 32'd1);
      check("t1.head",  32'(tdata_o), 32'h11);
    end
    check("t1.state_full", 32'(state_o), 32'd2);
    tdata_i = 8'h55;
    repeat (2) begin
      tick();
      check("t1.held_level", 32'(level_o), 32'd4);
      check("t1.held_tready", 32'(tready_o), 32'd0);
    end

    // T2: drain in order
    tvalid_i = 1'b0; tready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2.data", 32'(tdata_o), 32'(t1_data[i]));
      tick();
      check("t2.level", 32'(level_o), 32'(3 - i));
      check("t2.tready", 32'(tready_o), 32'd1);
    end
    check("t2.tvalid_end", 32'(tvalid_o), 32'd0);
    check("t2.state_empty", 32'(state_o), 32'd0);

    // T3: streaming at one word per cycle
    for (int i = 0; i < 32; i++) begin
      tvalid_i = 1'b1; tdata_i = 8'(i); tlast_i = ((i % 8) == 7);
      tick();
      check("t3.data",  32'(tdata_o), 32'(i));
      check("t3.tlast", 32'(tlast_o), 32'((i % 8) == 7));
      check("t3.level", 32'(level_o), 32'd1);
      check("t3.tvalid", 32'(tvalid_o), 32'd1);
    end
    tvalid_i = 1'b0; tlast_i = 1'b0;
    tick();
    check("t3.level_end", 32'(level_o), 32'd0);

    // T5: flush at level 3 wins over a concurrent push and pop
    tready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tvalid_i = 1'b1; tdata_i = 8'h60 + 8'(i);
      tick();
    end
    check("t5.level3", 32'(level_o), 32'd3);
    flush_i = 1'b1; tvalid_i = 1'b1; tdata_i = 8'hAA; tready_i = 1'b1;
    tick();
    flush_i = 1'b0; tvalid_i = 1'b0;
    check_empty_outputs("t5.flush");
    repeat (2) begin
      tick();
      check("t5.stay_empty", 32'(tvalid_o), 32'd0);
    end
    tready_i = 1'b0; tvalid_i = 1'b1; tdata_i = 8'h5A;
    tick();
    check("t5.after_flush", 32'(tdata_o), 32'h5A);
    check("t5.after_level", 32'(level_o), 32'd1);

    // T6: async reset in the middle of a cycle
    tdata_i = 8'h5B;
    tick();
    tvalid_i = 1'b0;
    check("t6.level2", 32'(level_o), 32'd2);
    #3 arstn_i = 1'b0;
    #1;
    check_empty_outputs("t6.async");
    check("t6.tdata", 32'(tdata_o), 32'h0);
    #1 arstn_i = 1'b1;
    tick();
    check_empty_outputs("t6.after");

    // T4: random handshakes on the 8-deep instance
    begin
      int lvl = 0;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic push, pop, stall;
      logic [16:0] held;
      while (got < 1000 && cyc < 20000) begin
        cyc++;
        if (!tvalid8_i && sent < 1000 && $urandom_range(0, 1) == 1) begin
          tvalid8_i = 1'b1;
          tdata8_i  = 16'($urandom);
          tlast8_i  = 1'($urandom_range(0, 1));
        end
        tready8_i = 1'($urandom_range(0, 1));
        #1;
        check("t4.tready", 32'(tready8_o), 32'(lvl < 8));
        check("t4.tvalid", 32'(tvalid8_o), 32'(lvl != 0));
        push  = tvalid8_i & tready8_o;
        pop   = tvalid8_o & tready8_i;
        stall = tvalid8_o & ~tready8_i;
        held  = {tlast8_o, tdata8_o};
        if (pop) begin
          if (exp_q.size() == 0) check("t4.underflow", 32'(exp_q.size()), 32'd1);
          else check("t4.data", 32'({tlast8_o, tdata8_o}), 32'(exp_q.pop_front()));
          got++;
        end
        if (push) begin
          exp_q.push_back({tlast8_i, tdata8_i});
          sent++;
        end
        tick();
        lvl = lvl + int'(push) - int'(pop);
        check("t4.level", 32'(level8_o), 32'(lvl));
        if (stall) check("t4.stall_hold", 32'({tlast8_o, tdata8_o}), 32'(held));
        if (push) tvalid8_i = 1'b0;
      end
      check("t4.words_out", 32'(got), 32'd1000);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
